multicycle_ctr: RTL and testbench

MULTICYCLE_CTR -- requirements
Module: multicycle_ctr

---
 rtl/multicycle_ctr.sv | 197 +++++++++++++++++++
 tb/tb_multicycle_ctr.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctr.sv
// -----------------------------------------------------------------------------
// multicycle_ctr
//   Main control FSM of a multicycle MIPS-style datapath. Steps each
//   instruction through FETCH/DECODE and an opcode-dependent tail
//   (memory, R-type, branch, jump) before returning to FETCH, driving the
//   datapath mux selects and write enables as Moore outputs. Also counts
//   instruction fetches since reset.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-high reset (forces FETCH, count 0)
//   opCode[5:0]  in   instruction[31:26] from the instruction register
//   pcWrite      out  unconditional PC write enable
//   pcWriteCond  out  PC write enable qualified by ALU zero (beq)
//   iorD         out  memory address select: 0 = PC, 1 = ALU out
//   memRead      out  memory read strobe
//   memWrite     out  memory write strobe
//   memToReg     out  register write data select: 1 = memory data
//   irWrite      out  instruction register load
//   aluSrcA      out  ALU A select: 0 = PC, 1 = register A
//   regWrite     out  register file write enable
//   regDst       out  register destination select: 1 = rd, 0 = rt
//   aluOp[1:0]   out  00 add, 01 subtract, 10 use funct field
//   pcSource[1:0] out PC source: 00 ALU result, 01 ALU out, 10 jump target
//   aluSrcB[1:0] out  ALU B select: 00 reg B, 01 const 4, 10 imm, 11 imm<<2
//   illegalOp    out  high in DECODE when opCode is unsupported
//   state[3:0]   out  current state encoding (debug)
//   instrCount[15:0] out number of fetches since reset, wraps at 16 bits
// -----------------------------------------------------------------------------
module multicycle_ctr (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opCode,
    output logic        pcWrite,
    output logic        pcWriteCond,
    output logic        iorD,
    output logic        memRead,
    output logic        memWrite,
    output logic        memToReg,
    output logic        irWrite,
    output logic        aluSrcA,
    output logic        regWrite,
    output logic        regDst,
    output logic [1:0]  aluOp,
    output logic [1:0]  pcSource,
    output logic [1:0]  aluSrcB,
    output logic        illegalOp,
    output logic [3:0]  state,
    output logic [15:0] instrCount
);

    typedef enum logic [3:0] {
        S_FETCH      = 4'd0,
        S_DECODE     = 4'd1,
        S_MEM_ADDR   = 4'd2,
        S_MEM_READ   = 4'd3,
        S_MEM_WB     = 4'd4,
        S_MEM_WRITE  = 4'd5,
        S_EXECUTE    = 4'd6,
        S_R_COMPLETE = 4'd7,
        S_BRANCH     = 4'd8,
        S_JUMP       = 4'd9
    } state_t;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_instr_count;
    logic        w_supported;

    assign w_supported = (opCode == OP_LW) || (opCode == OP_SW) ||
                         (opCode == OP_R)  || (opCode == OP_BEQ) ||
                         (opCode == OP_J);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Fetch counter: one increment per edge spent in FETCH, natural wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr_count <= '0;
        end else if (r_state == S_FETCH) begin
            r_instr_count <= r_instr_count + 16'd1;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (opCode)
                    OP_LW, OP_SW: w_next = S_MEM_ADDR;
                    OP_R:         w_next = S_EXECUTE;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
                    default:      w_next = S_FETCH;
                endcase
            end
            // opCode is re-decoded here; anything but lw/sw abandons the
            // instruction rather than guessing a memory direction.
            S_MEM_ADDR: begin
                if (opCode == OP_LW) begin
                    w_next = S_MEM_READ;
                end else if (opCode == OP_SW) begin
                    w_next = S_MEM_WRITE;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_MEM_READ: w_next = S_MEM_WB;
            S_EXECUTE:  w_next = S_R_COMPLETE;
            default:    w_next = S_FETCH;
        endcase
    end

    // Moore output decode
    always_comb begin
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        iorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        memToReg    = 1'b0;
        irWrite     = 1'b0;
        aluSrcA     = 1'b0;
        regWrite    = 1'b0;
        regDst      = 1'b0;
        aluOp       = 2'b00;
        pcSource    = 2'b00;
        aluSrcB     = 2'b00;
        illegalOp   = 1'b0;
        case (r_state)
            S_FETCH: begin
                memRead = 1'b1;
                irWrite = 1'b1;
                pcWrite = 1'b1;
                aluSrcB = 2'b01;
            end
            S_DECODE: begin
                aluSrcB   = 2'b11;
                illegalOp = ~w_supported;
            end
            S_MEM_ADDR: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
            end
            S_MEM_READ: begin
                memRead = 1'b1;
                iorD    = 1'b1;
            end
            S_MEM_WB: begin
                regWrite = 1'b1;
                memToReg = 1'b1;
            end
            S_MEM_WRITE: begin
                memWrite = 1'b1;
                iorD     = 1'b1;
            end
            S_EXECUTE: begin
                aluSrcA = 1'b1;
                aluOp   = 2'b10;
            end
            S_R_COMPLETE: begin
                regWrite = 1'b1;
                regDst   = 1'b1;
            end
            S_BRANCH: begin
                aluSrcA     = 1'b1;
                aluOp       = 2'b01;
                pcWriteCond = 1'b1;
                pcSource    = 2'b01;
            end
            S_JUMP: begin
                pcWrite  = 1'b1;
                pcSource = 2'b10;
            end
            default: ;
        endcase
    end

    assign state      = r_state;
    assign instrCount = r_instr_count;

endmodule

// File: tb/tb_multicycle_ctr.sv
module tb_multicycle_ctr;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opCode;
    logic        pcWrite, pcWriteCond, iorD, memRead, memWrite, memToReg;
    logic        irWrite, aluSrcA, regWrite, regDst, illegalOp;
    logic [1:0]  aluOp, pcSource, aluSrcB;
    logic [3:0]  state;
    logic [15:0] instrCount;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;
    logic [15:0] m_count;

    typedef struct packed {
        logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, memToReg;
        logic       irWrite, aluSrcA, regWrite, regDst, illegalOp;
        logic [1:0] aluOp, pcSource, aluSrcB;
    } ctl_t;

    multicycle_ctr dut (
        .clk(clk), .reset(reset), .opCode(opCode),
        .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD),
        .memRead(memRead), .memWrite(memWrite), .memToReg(memToReg),
        .irWrite(irWrite), .aluSrcA(aluSrcA), .regWrite(regWrite),
        .regDst(regDst), .aluOp(aluOp), .pcSource(pcSource),
        .aluSrcB(aluSrcB), .illegalOp(illegalOp), .state(state),
        .instrCount(instrCount)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                           BEQ = 6'b000100, JMP = 6'b000010;

    function automatic bit supported(input logic [5:0] op);
        return (op == LW) || (op == SW) || (op == RT) || (op == BEQ) || (op == JMP);
    endfunction

    // Sequence of states an instruction visits, starting at FETCH
    function automatic void path_of(input logic [5:0] op, output int p[$]);
        p = {0, 1};
        case (op)
            LW:      p = {0, 1, 2, 3, 4};
            SW:      p = {0, 1, 2, 5};
            RT:      p = {0, 1, 6, 7};
            BEQ:     p = {0, 1, 8};
            JMP:     p = {0, 1, 9};
            default: p = {0, 1};
        endcase
    endfunction

    // Control signals asserted in each state, straight from the state table
    function automatic ctl_t expect_ctl(input int s, input logic [5:0] op);
        ctl_t c = '0;
        case (s)
            0: begin c.memRead = 1; c.irWrite = 1; c.pcWrite = 1; c.aluSrcB = 2'b01; end
            1: begin c.aluSrcB = 2'b11; c.illegalOp = !supported(op); end
            2: begin c.aluSrcA = 1; c.aluSrcB = 2'b10; end
            3: begin c.memRead = 1; c.iorD = 1; end
            4: begin c.regWrite = 1; c.memToReg = 1; end
            5: begin c.memWrite = 1; c.iorD = 1; end
            6: begin c.aluSrcA = 1; c.aluOp = 2'b10; end
            7: begin c.regWrite = 1; c.regDst = 1; end
            8: begin c.aluSrcA = 1; c.aluOp = 2'b01; c.pcWriteCond = 1; c.pcSource = 2'b01; end
            9: begin c.pcWrite = 1; c.pcSource = 2'b10; end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic ctl_t dut_ctl();
        ctl_t c;
        c.pcWrite = pcWrite; c.pcWriteCond = pcWriteCond; c.iorD = iorD;
        c.memRead = memRead; c.memWrite = memWrite; c.memToReg = memToReg;
        c.irWrite = irWrite; c.aluSrcA = aluSrcA; c.regWrite = regWrite;
        c.regDst = regDst; c.illegalOp = illegalOp; c.aluOp = aluOp;
        c.pcSource = pcSource; c.aluSrcB = aluSrcB;
        return c;
    endfunction

    task automatic check(input string tag, input int exp_state);
        ctl_t act, exp;
        act = dut_ctl();
        exp = expect_ctl(exp_state, opCode);
        n_assert++;
        assert (state === 4'(exp_state)) else begin
            n_fail++;
            $error("FAIL %s state: observed %0d expected %0d", tag, state, exp_state);
        end
        n_assert++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s ctl (state %0d): observed %h expected %h", tag, exp_state, act, exp);
        end
        n_assert++;
        assert (instrCount === m_count) else begin
            n_fail++;
            $error("FAIL %s instrCount: observed %h expected %h", tag, instrCount, m_count);
        end
        n_assert++;
        assert ((memRead & memWrite) === 1'b0) else begin
            n_fail++;
            $error("FAIL %s memRead&memWrite: observed 1 expected 0", tag);
        end
    endtask

    // Runs one full instruction; called at a sample point with state FETCH
    task automatic run_instr(input string tag, input logic [5:0] op);
        int p[$];
        opCode = op;
        path_of(op, p);
        foreach (p[i]) begin
            check(tag, p[i]);
            @(posedge clk);
            if (p[i] == 0) m_count = m_count + 16'd1;
            #1;
        end
    endtask

    initial begin
        logic [5:0] op;
        reset = 1'b1;
        opCode = LW;
        m_count = '0;
        #1;
        check("reset_async", 0);
        @(posedge clk); #1;
        check("reset_held", 0);
        reset = 1'b0;

        run_instr("lw", LW);
        check("lw_refetch", 0);
        run_instr("sw", SW);
        run_instr("rtype", RT);
        run_instr("beq", BEQ);
        run_instr("j", JMP);
        run_instr("illegal", 6'b111111);
        check("illegal_refetch", 0);

        // Reset pulse between edges while in MEM_READ
        opCode = LW;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            if (i == 0) m_count = m_count + 16'd1;
            #1;
        end
        check("pre_reset_memread", 3);
        #2 reset = 1'b1;
        m_count = '0;
        #1 check("mid_reset", 0);
        #1 reset = 1'b0;
        run_instr("post_reset_lw", LW);

        // Counter wrap
        force dut.r_instr_count = 16'hFFFF;
        #1 release dut.r_instr_count;
        m_count = 16'hFFFF;
        check("wrap_pre", 0);
        run_instr("wrap", JMP);

        // Randomized instruction stream
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 5))
                0: op = LW;
                1: op = SW;
                2: op = RT;
                3: op = BEQ;
                4: op = JMP;
                default: op = 6'($urandom);
            endcase
            run_instr("random", op);
        end
        check("final", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
